// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: streams one cache block from pipelined main memory into the data array, then writes the tag.
// Optional critical-word-first ordering is enabled by defining CACHE_FILL_CWF_EN.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic [15:0]           memory_data,
  input  logic                  memory_data_valid,
  output logic                  fsm_busy,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  write_data_array,
  output logic [ADDR_WIDTH-1:0] fill_address,
  output logic [15:0]           fill_data,
  output logic                  write_tag_array
);

  localparam int OW = $clog2(WORDS_PER_BLOCK);
  localparam int CW = OW + 1;
  localparam int TW = ADDR_WIDTH - OW - 1;
  localparam logic [CW-1:0] W_CNT = CW'(WORDS_PER_BLOCK);

  typedef enum logic {IDLE, FILL} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] ic, rc;
  logic [TW-1:0] tag_bits;
  logic [OW-1:0] start;
  logic [OW-1:0] issue_off, ret_off;
  logic          unused_addr_bits;

  // Byte-select bit never reaches the outputs; word-offset bits only matter with critical-word-first.
  assign unused_addr_bits = ^miss_address[OW:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ic    <= '0;
      rc    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        ic <= '0;
        rc <= '0;
      end else begin
        if (ic != W_CNT) ic <= ic + 1'b1;
        if (memory_data_valid) rc <= rc + 1'b1;
      end
    end
  end

  // Block base and start offset are data: only meaningful while in FILL, so no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && miss_detected) begin
      tag_bits <= miss_address[ADDR_WIDTH-1:OW+1];
`ifdef CACHE_FILL_CWF_EN
      start    <= miss_address[OW:1];
`else
      start    <= '0;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (miss_detected) state_nxt = FILL;
      FILL: if (memory_data_valid && rc == W_CNT - 1'b1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Offsets wrap inside the block, so the tag bits are never carried into.
  always_comb begin
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_address     = '0;
    fill_data        = memory_data;
    write_tag_array  = 1'b0;
    issue_off        = start + ic[OW-1:0];
    ret_off          = start + rc[OW-1:0];
    if (state == FILL) begin
      fsm_busy = 1'b1;
      if (ic != W_CNT) begin
        mem_en         = 1'b1;
        memory_address = {tag_bits, issue_off, 1'b0};
      end
      if (memory_data_valid) begin
        write_data_array = 1'b1;
        fill_address     = {tag_bits, ret_off, 1'b0};
        write_tag_array  = (rc == W_CNT - 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a 4-cycle pipelined memory model; expectations follow CACHE_FILL_CWF_EN.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0;
  logic [15:0] memory_data = 16'h0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy, mem_en, write_data_array, write_tag_array;
  logic [15:0] memory_address, fill_address, fill_data;

`ifdef CACHE_FILL_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  always #5 clk = ~clk;

  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected), .miss_address(miss_address),
    .memory_data(memory_data), .memory_data_valid(memory_data_valid), .fsm_busy(fsm_busy),
    .mem_en(mem_en), .memory_address(memory_address), .write_data_array(write_data_array),
    .fill_address(fill_address), .fill_data(fill_data), .write_tag_array(write_tag_array)
  );

  int          cyc = 0;
  bit          sched_v[int];
  logic [15:0] sched_d[int];
  logic [15:0] req_q[$], wa_q[$], wd_q[$];
  int          req_cyc_q[$], wr_cyc_q[$];
  int          tag_cnt, tag_pos, busy_cnt;
  logic [15:0] tag_addr;
  int          vectors = 0, miscompares = 0;

  // Memory model: responds 4 cycles after each request, in order, with addr ^ 5A5A.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (sched_v.exists(cyc)) begin
      memory_data_valid = 1'b1;
      memory_data = sched_d[cyc];
      sched_v.delete(cyc);
    end else begin
      memory_data_valid = 1'b0;
      memory_data = 16'h0;
    end
  end

  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      req_q.push_back(memory_address);
      req_cyc_q.push_back(cyc);
      sched_v[cyc+4] = 1'b1;
      sched_d[cyc+4] = memory_address ^ 16'h5A5A;
    end
    if (write_data_array === 1'b1) begin
      wa_q.push_back(fill_address);
      wd_q.push_back(fill_data);
      wr_cyc_q.push_back(cyc);
    end
    if (write_tag_array === 1'b1) begin
      tag_cnt++;
      tag_addr = fill_address;
      tag_pos = wa_q.size();
    end
    if (fsm_busy === 1'b1) busy_cnt++;
  end

  function automatic logic [15:0] exp_addr(input logic [15:0] miss, input int i);
    int s;
    s = CWF ? int'(miss[3:1]) : 0;
    return (miss & 16'hFFF0) | 16'(((s + i) % 8) * 2);
  endfunction

  task automatic clear_log();
    req_q.delete(); wa_q.delete(); wd_q.delete(); req_cyc_q.delete(); wr_cyc_q.delete();
    tag_cnt = 0; tag_pos = 0; busy_cnt = 0; tag_addr = 16'h0;
  endtask

  task automatic run_miss(input logic [15:0] a, input int pulse_at, input logic [15:0] pulse_addr,
                          output bit timeout);
    @(posedge clk); #1;
    clear_log();
    miss_detected = 1'b1; miss_address = a;
    @(posedge clk); #1;
    miss_detected = 1'b0; miss_address = 16'h0;
    timeout = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (pulse_at > 0 && i == pulse_at) begin
        miss_detected = 1'b1; miss_address = pulse_addr;
      end else if (pulse_at > 0 && i == pulse_at + 1) begin
        miss_detected = 1'b0; miss_address = 16'h0;
      end
      if (fsm_busy === 1'b0) begin
        timeout = 1'b0;
        break;
      end
    end
    miss_detected = 1'b0;
  endtask

  task automatic test_reset();
    logic [84:0] outs;
    rst_n = 1'b0; miss_detected = 1'b1; miss_address = 16'h1236;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        miss_detected = 1'b0; miss_address = 16'h0; rst_n = 1'b1;
      end
      @(negedge clk); #1;
      outs = {fsm_busy, mem_en, memory_address, write_data_array, fill_address, fill_data,
              write_tag_array, 32'h0};
      vectors++;
      if (outs !== 85'h0) begin
        miscompares++;
        $display("FAIL reset_outputs[%0d]: busy=%b mem_en=%b maddr=%h wda=%b faddr=%h fdata=%h wta=%b, required all 0",
                 i, fsm_busy, mem_en, memory_address, write_data_array, fill_address, fill_data, write_tag_array);
      end
    end
  endtask

  task automatic test_basic_fill();
    bit to;
    run_miss(16'h1236, 0, 16'h0, to);
    vectors++;
    if (to !== 1'b0) begin miscompares++; $display("FAIL basic_done: timeout=%b required 0", to); end
    vectors++;
    if (req_q.size() != 8) begin miscompares++; $display("FAIL basic_req_count: %0d required 8", req_q.size()); end
    for (int i = 0; i < req_q.size() && i < 8; i++) begin
      vectors++;
      if (req_q[i] !== exp_addr(16'h1236, i) || req_cyc_q[i] - req_cyc_q[0] != i) begin
        miscompares++;
        $display("FAIL basic_req[%0d]: addr=%h cyc+%0d required addr=%h cyc+%0d", i, req_q[i],
                 req_cyc_q[i] - req_cyc_q[0], exp_addr(16'h1236, i), i);
      end
    end
    vectors++;
    if (wa_q.size() != 8) begin miscompares++; $display("FAIL basic_wr_count: %0d required 8", wa_q.size()); end
    for (int i = 0; i < wa_q.size() && i < 8 && req_cyc_q.size() > 0; i++) begin
      vectors++;
      if (wa_q[i] !== exp_addr(16'h1236, i) || wd_q[i] !== (exp_addr(16'h1236, i) ^ 16'h5A5A) ||
          wr_cyc_q[i] - req_cyc_q[0] != i + 4) begin
        miscompares++;
        $display("FAIL basic_wr[%0d]: addr=%h data=%h cyc+%0d required addr=%h data=%h cyc+%0d", i, wa_q[i], wd_q[i],
                 wr_cyc_q[i] - req_cyc_q[0], exp_addr(16'h1236, i), exp_addr(16'h1236, i) ^ 16'h5A5A, i + 4);
      end
    end
    vectors++;
    if (tag_cnt != 1 || tag_pos != 8 || (tag_addr & 16'hFFF0) !== 16'h1230) begin
      miscompares++;
      $display("FAIL basic_tag: count=%0d with_write=%0d block=%h required 1, 8, 1230", tag_cnt, tag_pos, tag_addr & 16'hFFF0);
    end
    vectors++;
    if (busy_cnt != 12) begin miscompares++; $display("FAIL basic_busy_cycles: %0d required 12", busy_cnt); end
  endtask

  task automatic test_cwf_wrap();
    bit to;
    run_miss(16'h123A, 0, 16'h0, to);
    vectors++;
    if (to !== 1'b0 || req_q.size() != 8 || wa_q.size() != 8) begin
      miscompares++;
      $display("FAIL wrap_counts: timeout=%b reqs=%0d writes=%0d required 0, 8, 8", to, req_q.size(), wa_q.size());
    end
    for (int i = 0; i < req_q.size() && i < wa_q.size() && i < 8; i++) begin
      vectors++;
      if (req_q[i] !== exp_addr(16'h123A, i) || wa_q[i] !== exp_addr(16'h123A, i)) begin
        miscompares++;
        $display("FAIL wrap_order[%0d]: req=%h fill=%h required %h", i, req_q[i], wa_q[i], exp_addr(16'h123A, i));
      end
    end
  endtask

  task automatic test_top_block();
    bit to;
    run_miss(16'hFFFE, 0, 16'h0, to);
    vectors++;
    if (to !== 1'b0 || req_q.size() != 8 || wa_q.size() != 8 || tag_cnt != 1) begin
      miscompares++;
      $display("FAIL top_counts: timeout=%b reqs=%0d writes=%0d tags=%0d required 0, 8, 8, 1", to, req_q.size(), wa_q.size(), tag_cnt);
    end
    for (int i = 0; i < req_q.size() && i < wa_q.size() && i < 8; i++) begin
      vectors++;
      if (req_q[i] < 16'hFFF0 || req_q[i] !== exp_addr(16'hFFFE, i) || wa_q[i] !== exp_addr(16'hFFFE, i)) begin
        miscompares++;
        $display("FAIL top_addr[%0d]: req=%h fill=%h required %h", i, req_q[i], wa_q[i], exp_addr(16'hFFFE, i));
      end
    end
  endtask

  task automatic test_miss_during_busy();
    bit to;
    int stray;
    run_miss(16'h2000, 3, 16'h4000, to);
    stray = 0;
    foreach (req_q[i]) if (req_q[i][15:4] !== 12'h200) stray++;
    vectors++;
    if (to !== 1'b0 || stray != 0 || req_q.size() != 8 || wa_q.size() != 8 || tag_cnt != 1) begin
      miscompares++;
      $display("FAIL busy_miss_fill: timeout=%b stray=%0d reqs=%0d writes=%0d tags=%0d required 0, 0, 8, 8, 1",
               to, stray, req_q.size(), wa_q.size(), tag_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      vectors++;
      if (fsm_busy !== 1'b0 || mem_en !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_miss_not_queued[%0d]: busy=%b mem_en=%b required 0, 0", i, fsm_busy, mem_en);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    bit to, reached;
    @(posedge clk); #1;
    clear_log();
    miss_detected = 1'b1; miss_address = 16'h3000;
    @(posedge clk); #1;
    miss_detected = 1'b0; miss_address = 16'h0;
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (wa_q.size() == 3) begin
        rst_n = 1'b0; reached = 1'b1;
        break;
      end
    end
    vectors++;
    if (reached !== 1'b1) begin miscompares++; $display("FAIL midreset_third_valid: reached=%b required 1", reached); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (fsm_busy !== 1'b0 || mem_en !== 1'b0 || write_tag_array !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_idle: busy=%b mem_en=%b wta=%b required 0, 0, 0", fsm_busy, mem_en, write_tag_array);
    end
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (tag_cnt != 0 || wa_q.size() != 3) begin
      miscompares++;
      $display("FAIL midreset_no_tag: tags=%0d writes=%0d required 0, 3", tag_cnt, wa_q.size());
    end
    run_miss(16'h5000, 0, 16'h0, to);
    vectors++;
    if (to !== 1'b0 || req_q.size() != 8 || wa_q.size() != 8 || tag_cnt != 1 || busy_cnt != 12) begin
      miscompares++;
      $display("FAIL midreset_restart: timeout=%b reqs=%0d writes=%0d tags=%0d busy=%0d required 0, 8, 8, 1, 12",
               to, req_q.size(), wa_q.size(), tag_cnt, busy_cnt);
    end
    for (int i = 0; i < req_q.size() && i < wa_q.size() && i < 8; i++) begin
      vectors++;
      if (req_q[i] !== exp_addr(16'h5000, i) || wa_q[i] !== exp_addr(16'h5000, i) ||
          wd_q[i] !== (exp_addr(16'h5000, i) ^ 16'h5A5A)) begin
        miscompares++;
        $display("FAIL midreset_refill[%0d]: req=%h fill=%h data=%h required %h, %h, %h", i, req_q[i], wa_q[i], wd_q[i],
                 exp_addr(16'h5000, i), exp_addr(16'h5000, i), exp_addr(16'h5000, i) ^ 16'h5A5A);
      end
    end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_basic_fill();
    test_cwf_wrap();
    test_top_block();
    test_miss_during_busy();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
